// File: rtl/router_pkg.sv
// router_pkg: shared types and constants for the 1x3 router.
// Holds the FSM state encoding, the reserved address and a flag selector.
package router_pkg;

  localparam int          NUM_PORTS    = 3;
  localparam logic [1:0]  ADDR_INVALID = 2'b11;

  typedef enum logic [2:0] {
    DECODE_ADDRESS     = 3'd0,
    LOAD_FIRST_DATA    = 3'd1,
    LOAD_DATA          = 3'd2,
    LOAD_PARITY        = 3'd3,
    FIFO_FULL_STATE    = 3'd4,
    LOAD_AFTER_FULL    = 3'd5,
    WAIT_TILL_EMPTY    = 3'd6,
    CHECK_PARITY_ERROR = 3'd7
  } state_t;

  // Pick one per-port flag; the reserved address reads as 0.
  function automatic logic sel3(
    input logic [2:0] v,
    input logic [1:0] a
  );
    case (a)
      2'd0:    return v[0];
      2'd1:    return v[1];
      2'd2:    return v[2];
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/router_fsm.sv
// router_fsm: packet-reception controller for the 1x3 router.
// Sequences header/payload/parity, stalls the source on full or busy FIFO.
// Inputs : clk, resetn (sync, active low), pkt_valid, data_in[1:0],
//          parity_done, low_pkt_valid, fifo_full, fifo_empty_0/1/2,
//          soft_reset_0/1/2
// Outputs: detect_add, lfd_state, ld_state, full_state, laf_state,
//          rst_int_reg, write_enb_reg, busy (all Moore)
module router_fsm
  import router_pkg::*;
(
  input  logic       clk,
  input  logic       resetn,
  input  logic       pkt_valid,
  input  logic [1:0] data_in,
  input  logic       parity_done,
  input  logic       low_pkt_valid,
  input  logic       fifo_full,
  input  logic       fifo_empty_0,
  input  logic       fifo_empty_1,
  input  logic       fifo_empty_2,
  input  logic       soft_reset_0,
  input  logic       soft_reset_1,
  input  logic       soft_reset_2,
  output logic       detect_add,
  output logic       lfd_state,
  output logic       ld_state,
  output logic       full_state,
  output logic       laf_state,
  output logic       rst_int_reg,
  output logic       write_enb_reg,
  output logic       busy
);

  state_t     r_state;
  state_t     w_next;
  logic [1:0] r_addr_q;

  logic [2:0] w_empty;
  logic [2:0] w_soft;
  logic       w_hdr_ok;
  logic       w_hdr_empty;
  logic       w_sel_empty;
  logic       w_sel_soft;

  assign w_empty = {fifo_empty_2, fifo_empty_1, fifo_empty_0};
  assign w_soft  = {soft_reset_2, soft_reset_1, soft_reset_0};

  assign w_hdr_ok    = pkt_valid && (data_in != ADDR_INVALID);
  // In DA the header address is live; afterwards use the latched one.
  assign w_hdr_empty = sel3(w_empty, data_in);
  assign w_sel_empty = sel3(w_empty, r_addr_q);
  assign w_sel_soft  = sel3(w_soft, r_addr_q);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state  <= DECODE_ADDRESS;
      r_addr_q <= 2'b00;
    end else begin
      r_state <= w_next;
      if (r_state == DECODE_ADDRESS && w_hdr_ok)
        r_addr_q <= data_in;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      DECODE_ADDRESS:
        if (w_hdr_ok)
          w_next = w_hdr_empty ? LOAD_FIRST_DATA
                               : WAIT_TILL_EMPTY;
      WAIT_TILL_EMPTY:
        if (w_sel_empty) w_next = LOAD_FIRST_DATA;
      LOAD_FIRST_DATA:
        w_next = LOAD_DATA;
      LOAD_DATA:
        if (fifo_full)       w_next = FIFO_FULL_STATE;
        else if (!pkt_valid) w_next = LOAD_PARITY;
      FIFO_FULL_STATE:
        if (!fifo_full) w_next = LOAD_AFTER_FULL;
      LOAD_AFTER_FULL:
        if (parity_done)        w_next = DECODE_ADDRESS;
        else if (low_pkt_valid) w_next = LOAD_PARITY;
        else                    w_next = LOAD_DATA;
      LOAD_PARITY:
        w_next = CHECK_PARITY_ERROR;
      CHECK_PARITY_ERROR:
        w_next = fifo_full ? FIFO_FULL_STATE
                           : DECODE_ADDRESS;
      default:
        w_next = DECODE_ADDRESS;
    endcase
    // Timeout reset of the selected FIFO aborts the packet.
    if (r_state != DECODE_ADDRESS && w_sel_soft)
      w_next = DECODE_ADDRESS;
  end

  assign detect_add    = (r_state == DECODE_ADDRESS);
  assign lfd_state     = (r_state == LOAD_FIRST_DATA);
  assign ld_state      = (r_state == LOAD_DATA);
  assign full_state    = (r_state == FIFO_FULL_STATE);
  assign laf_state     = (r_state == LOAD_AFTER_FULL);
  assign rst_int_reg   = (r_state == CHECK_PARITY_ERROR);
  assign write_enb_reg = (r_state == LOAD_DATA)
                      || (r_state == LOAD_PARITY)
                      || (r_state == LOAD_AFTER_FULL);
  assign busy          = (r_state != DECODE_ADDRESS)
                      && (r_state != LOAD_DATA);

endmodule

// File: tb/tb_router_fsm.sv
// tb_router_fsm: directed self-checking bench for router_fsm.
// Each task drives a step table and compares the Moore output vector.
module tb_router_fsm;

  logic       clk = 1'b0;
  logic       resetn;
  logic       pkt_valid;
  logic [1:0] data_in;
  logic       parity_done;
  logic       low_pkt_valid;
  logic       fifo_full;
  logic       fifo_empty_0;
  logic       fifo_empty_1;
  logic       fifo_empty_2;
  logic       soft_reset_0;
  logic       soft_reset_1;
  logic       soft_reset_2;
  logic       detect_add;
  logic       lfd_state;
  logic       ld_state;
  logic       full_state;
  logic       laf_state;
  logic       rst_int_reg;
  logic       write_enb_reg;
  logic       busy;

  int n_pass  = 0;
  int n_total = 0;

  // {detect_add,lfd,ld,full,laf,rst_int,write_enb,busy}
  localparam logic [7:0] E_DA  = 8'b1000_0000;
  localparam logic [7:0] E_LFD = 8'b0100_0001;
  localparam logic [7:0] E_LD  = 8'b0010_0010;
  localparam logic [7:0] E_LP  = 8'b0000_0011;
  localparam logic [7:0] E_FFS = 8'b0001_0001;
  localparam logic [7:0] E_LAF = 8'b0000_1011;
  localparam logic [7:0] E_WTE = 8'b0000_0001;
  localparam logic [7:0] E_CPE = 8'b0000_0101;

  // stimulus bits: {pv,ff,lpv,pd,sr0,sr1,sr2}
  localparam logic [6:0] PV  = 7'b1000000;
  localparam logic [6:0] FF  = 7'b0100000;
  localparam logic [6:0] LPV = 7'b0010000;
  localparam logic [6:0] PD  = 7'b0001000;
  localparam logic [6:0] SR0 = 7'b0000100;
  localparam logic [6:0] SR1 = 7'b0000010;
  localparam logic [6:0] SR2 = 7'b0000001;

  logic [7:0] obs;
  assign obs = {detect_add, lfd_state, ld_state, full_state,
                laf_state, rst_int_reg, write_enb_reg, busy};

  router_fsm dut (
    .clk(clk), .resetn(resetn), .pkt_valid(pkt_valid),
    .data_in(data_in), .parity_done(parity_done),
    .low_pkt_valid(low_pkt_valid), .fifo_full(fifo_full),
    .fifo_empty_0(fifo_empty_0), .fifo_empty_1(fifo_empty_1),
    .fifo_empty_2(fifo_empty_2), .soft_reset_0(soft_reset_0),
    .soft_reset_1(soft_reset_1), .soft_reset_2(soft_reset_2),
    .detect_add(detect_add), .lfd_state(lfd_state),
    .ld_state(ld_state), .full_state(full_state),
    .laf_state(laf_state), .rst_int_reg(rst_int_reg),
    .write_enb_reg(write_enb_reg), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic apply(input logic [6:0] s);
    {pkt_valid, fifo_full, low_pkt_valid, parity_done,
     soft_reset_0, soft_reset_1, soft_reset_2} = s;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    data_in = 2'b01;
    apply(PV);
    fifo_empty_0 = 1'b1;
    fifo_empty_1 = 1'b1;
    fifo_empty_2 = 1'b1;
    tick();
    tick();
    n_total++;
    if (obs !== E_DA)
      $display("FAIL reset_out: got %b want %b", obs, E_DA);
    else n_pass++;
    n_total++;
    if (dut.r_addr_q !== 2'b00)
      $display("FAIL reset_addr: got %b want 00", dut.r_addr_q);
    else n_pass++;
    apply(7'b0);
    resetn = 1'b1;
    tick();
    n_total++;
    if (obs !== E_DA)
      $display("FAIL reset_idle: got %b want %b", obs, E_DA);
    else n_pass++;
  endtask

  task automatic test_normal();
    logic [14:0] t [7] = '{
      {PV, E_LFD}, {PV, E_LD}, {PV, E_LD}, {PV, E_LD},
      {7'b0, E_LP}, {7'b0, E_CPE}, {7'b0, E_DA}};
    data_in = 2'b01;
    foreach (t[i]) begin
      apply(t[i][14:8]);
      tick();
      n_total++;
      if (obs !== t[i][7:0])
        $display("FAIL normal[%0d]: got %b want %b",
                 i, obs, t[i][7:0]);
      else n_pass++;
    end
    n_total++;
    if (dut.r_addr_q !== 2'b01)
      $display("FAIL normal_addr: got %b want 01", dut.r_addr_q);
    else n_pass++;
  endtask

  task automatic test_busy_dest();
    logic [14:0] t [10] = '{
      {PV, E_WTE}, {7'b0, E_WTE}, {7'b0, E_WTE},
      {7'b0, E_WTE}, {7'b0, E_WTE}, {7'b0, E_LFD},
      {7'b0, E_LD}, {7'b0, E_LP}, {7'b0, E_CPE},
      {7'b0, E_DA}};
    data_in = 2'b10;
    fifo_empty_2 = 1'b0;
    foreach (t[i]) begin
      if (i == 5) fifo_empty_2 = 1'b1;
      apply(t[i][14:8]);
      tick();
      n_total++;
      if (obs !== t[i][7:0])
        $display("FAIL busy_dest[%0d]: got %b want %b",
                 i, obs, t[i][7:0]);
      else n_pass++;
    end
  endtask

  task automatic test_full_mid();
    logic [14:0] t [10] = '{
      {PV, E_LFD}, {PV, E_LD}, {PV|FF, E_FFS},
      {PV|FF, E_FFS}, {PV|FF, E_FFS}, {PV, E_LAF},
      {PV, E_LD}, {7'b0, E_LP}, {7'b0, E_CPE},
      {7'b0, E_DA}};
    data_in = 2'b00;
    foreach (t[i]) begin
      apply(t[i][14:8]);
      tick();
      n_total++;
      if (obs !== t[i][7:0])
        $display("FAIL full_mid[%0d]: got %b want %b",
                 i, obs, t[i][7:0]);
      else n_pass++;
    end
  endtask

  task automatic test_full_end();
    logic [14:0] a [9] = '{
      {PV, E_LFD}, {PV, E_LD}, {FF, E_FFS}, {7'b0, E_LAF},
      {LPV, E_LP}, {7'b0, E_CPE}, {FF, E_FFS},
      {7'b0, E_LAF}, {PD, E_DA}};
    logic [14:0] b [5] = '{
      {PV, E_LFD}, {PV, E_LD}, {FF, E_FFS}, {7'b0, E_LAF},
      {PD, E_DA}};
    data_in = 2'b01;
    foreach (a[i]) begin
      apply(a[i][14:8]);
      tick();
      n_total++;
      if (obs !== a[i][7:0])
        $display("FAIL full_lowpv[%0d]: got %b want %b",
                 i, obs, a[i][7:0]);
      else n_pass++;
    end
    apply(7'b0);
    data_in = 2'b10;
    foreach (b[i]) begin
      apply(b[i][14:8]);
      tick();
      n_total++;
      if (obs !== b[i][7:0])
        $display("FAIL full_parity[%0d]: got %b want %b",
                 i, obs, b[i][7:0]);
      else n_pass++;
    end
    apply(7'b0);
  endtask

  task automatic test_invalid_addr();
    data_in = 2'b11;
    for (int i = 0; i < 3; i++) begin
      apply(PV);
      tick();
      n_total++;
      if (obs !== E_DA)
        $display("FAIL inv_addr[%0d]: got %b want %b",
                 i, obs, E_DA);
      else n_pass++;
    end
    n_total++;
    if (dut.r_addr_q !== 2'b10)
      $display("FAIL inv_addr_q: got %b want 10", dut.r_addr_q);
    else n_pass++;
    apply(7'b0);
  endtask

  task automatic test_soft_reset();
    logic [14:0] t [5] = '{
      {PV, E_LFD}, {PV, E_LD}, {PV|SR1, E_LD},
      {PV|SR2, E_LD}, {PV|SR0, E_DA}};
    data_in = 2'b00;
    foreach (t[i]) begin
      apply(t[i][14:8]);
      tick();
      n_total++;
      if (obs !== t[i][7:0])
        $display("FAIL soft_rst[%0d]: got %b want %b",
                 i, obs, t[i][7:0]);
      else n_pass++;
    end
    apply(7'b0);
    tick();
    // Soft reset while waiting for a busy FIFO.
    data_in = 2'b10;
    fifo_empty_2 = 1'b0;
    apply(PV);
    tick();
    n_total++;
    if (obs !== E_WTE)
      $display("FAIL soft_wte_in: got %b want %b", obs, E_WTE);
    else n_pass++;
    apply(SR2);
    tick();
    n_total++;
    if (obs !== E_DA)
      $display("FAIL soft_wte_out: got %b want %b", obs, E_DA);
    else n_pass++;
    apply(7'b0);
    fifo_empty_2 = 1'b1;
  endtask

  initial begin
    test_reset();
    test_normal();
    test_busy_dest();
    test_full_mid();
    test_full_end();
    test_invalid_addr();
    test_soft_reset();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/router_fsm.md
Name: router_fsm

Overview:
Packet-reception controller for the 1x3 router. It sequences the header, payload and parity phases of each incoming packet and stalls the source when the selected output FIFO is full or not yet drained. It drives the enables used by the register block and by the synchronizer, which converts write_enb_reg/detect_add into per-FIFO write enables. It sits between the source interface and the register/synchronizer blocks.

Parameters:
none — port count fixed at 3; address 2'b11 reserved/invalid

Ports:
clk  input  1  system clock, all logic on rising edge
resetn  input  1  synchronous active-low reset
pkt_valid  input  1  source asserts for header+payload bytes, deasserts with parity byte
data_in  input  2  destination address field of header byte (bits [1:0])
parity_done  input  1  register block: parity byte has been loaded
low_pkt_valid  input  1  register block: pkt_valid fell while FSM was stalled on full
fifo_full  input  1  full flag of currently selected FIFO (from synchronizer)
fifo_empty_0/1/2  input  1 each  empty flags of output FIFOs
soft_reset_0/1/2  input  1 each  per-FIFO timeout resets from synchronizer
detect_add  output  1  FSM in DECODE_ADDRESS
lfd_state  output  1  FSM in LOAD_FIRST_DATA
ld_state  output  1  FSM in LOAD_DATA
full_state  output  1  FSM in FIFO_FULL_STATE
laf_state  output  1  FSM in LOAD_AFTER_FULL
rst_int_reg  output  1  FSM in CHECK_PARITY_ERROR
write_enb_reg  output  1  LOAD_DATA | LOAD_PARITY | LOAD_AFTER_FULL
busy  output  1  source must hold data; all states except DECODE_ADDRESS and LOAD_DATA

Behaviour:
- States: DECODE_ADDRESS (DA), LOAD_FIRST_DATA (LFD), LOAD_DATA (LD), LOAD_PARITY (LP), FIFO_FULL_STATE (FFS), LOAD_AFTER_FULL (LAF), WAIT_TILL_EMPTY (WTE), CHECK_PARITY_ERROR (CPE).
- Reset (resetn=0 at clk edge): state=DA, addr_q=2'b00. Outputs then: detect_add=1, all others 0.
- addr_q: 2-bit register, loaded from data_in on any cycle in DA with pkt_valid=1 and data_in!=2'b11. Selects the fifo_empty_x and soft_reset_x flags used in all states after DA.
- Transitions:
  - DA:
    - pkt_valid & data_in!=3 & fifo_empty[data_in] -> LFD
    - pkt_valid & data_in!=3 & !fifo_empty[data_in] -> WTE
    - otherwise stay; data_in=3 is dropped, no state change
  - WTE: fifo_empty[addr_q] -> LFD, else stay.
  - LFD: -> LD unconditionally (one cycle).
  - LD: fifo_full -> FFS; else !pkt_valid -> LP; else stay. fifo_full has priority.
  - FFS: !fifo_full -> LAF, else stay.
  - LAF:
    - parity_done -> DA
    - !parity_done & low_pkt_valid -> LP
    - !parity_done & !low_pkt_valid -> LD
  - LP: -> CPE unconditionally.
  - CPE: fifo_full -> FFS, else DA.
- Soft reset: soft_reset[addr_q]=1 in any state other than DA forces next state DA. This has priority over all other transitions except resetn.
- All outputs are Moore, decoded from the registered state with no input-to-output paths.
- Latency: a header accepted in DA produces lfd_state on the next cycle. Packet end (pkt_valid falls in LD) reaches LP after 1 cycle and rst_int_reg after 2.
- Illegal/unused state encodings recover to DA on the next clock.

Decomposition:
- Shared package router_pkg:
  - state enum/localparams (3-bit encodings)
  - ADDR_INVALID=2'b11
  - NUM_PORTS=3
- No sub-module; a single always block for state/addr_q plus combinational next-state and output decode.

Test Plan:
- Reset: resetn=0 for 2 clks with pkt_valid=1 -> state DA, detect_add=1, busy=0, write_enb_reg=0.
- Normal packet to port 1:
  - stimulus: all FIFOs empty; DA with pkt_valid=1, data_in=01; 3 payload cycles, then pkt_valid=0
  - response: DA->LFD->LD x3->LP->CPE->DA; busy=1 only in LFD/LP/CPE; write_enb_reg=1 in LD and LP.
- Busy destination:
  - stimulus: data_in=10, fifo_empty_2=0 for 5 clks, then 1
  - response: WTE held 5 clks with busy=1, then LFD.
- FIFO full mid-packet:
  - stimulus: in LD, fifo_full=1 for 3 clks with low_pkt_valid=0, parity_done=0
  - response: FFS for 3 clks (full_state=1, busy=1), then LAF, then LD.
- Full with packet ended:
  - stimulus: in LAF with low_pkt_valid=1 -> LP -> CPE; in a separate run, LAF with parity_done=1
  - response: first run goes LP then CPE; second run returns to DA.
- Soft reset and invalid address:
  - stimulus: DA with data_in=11, pkt_valid=1 for 3 clks
  - response: stays DA, addr_q unchanged.
  - stimulus: in LD with addr_q=00, soft_reset_0=1
  - response: next state DA; soft_reset_1=1 in the same scenario has no effect.
